matvec_seq: RTL and testbench
=============================

MATVEC_SEQ -- requirements
Module: matvec_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width.
REQ-002 SHALL have parameter DEPTH, default 8, elements per row/vector (= FIFO depth).
REQ-003 SHALL have parameter NUM_ROWS, default 8, number of A FIFOs / MAC rows.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8, memory address width.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 start  input  1  one-cycle pulse; begins a job when IDLE.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse at job end.
REQ-010 mem_rd_req  output  1  memory read request, held until accepted by mem_rd_valid.
REQ-011 mem_addr  output  ADDR_WIDTH  read address, stable while mem_rd_req high.
REQ-012 mem_rd_valid  input  1  response strobe for the single outstanding request.
REQ-013 mem_rd_data  input  DATA_WIDTH  response data, valid with mem_rd_valid.
REQ-014 wr_data  output  DATA_WIDTH  shared FIFO write data.
REQ-015 b_wr_en  output  1  write strobe, B FIFO.
REQ-016 a_wr_en  output  NUM_ROWS  one-hot write strobes, A FIFOs.
REQ-017 b_rd_en  output  1  read strobe, B FIFO.
REQ-018 a_rd_en  output  NUM_ROWS  read strobes, A FIFOs.
REQ-019 mac_clr  output  1  one-cycle clear of all MAC accumulators.
REQ-020 mac_en  output  NUM_ROWS  per-row MAC accumulate enable.

Function
REQ-021 SHALL implement states IDLE, LOAD_B, LOAD_A, COMPUTE, DONE.
REQ-022 IDLE->LOAD_B on start; mac_clr SHALL pulse the cycle after start is accepted.
REQ-023 start outside IDLE (incl. DONE) SHALL be ignored.
REQ-024 At most one memory request outstanding; next mem_rd_req no earlier than cycle after mem_rd_valid.
REQ-025 LOAD_B: addresses 0..DEPTH-1 in order; each mem_rd_valid -> b_wr_en=1, wr_data=mem_rd_data next cycle.
REQ-026 LOAD_A: row r, column c read from address DEPTH*(r+1)+c, r outer, c inner; write -> a_wr_en bit r only.
REQ-027 Element counter SHALL wrap c DEPTH-1->0 and increment r; after r=NUM_ROWS-1, c=DEPTH-1 written, go COMPUTE.
REQ-028 mem_rd_valid while no request outstanding SHALL be ignored (no write, no count).
REQ-029 COMPUTE cycle counter k starts at 0 on entry; length DEPTH+NUM_ROWS cycles.
REQ-030 b_rd_en=1 for k in 0..DEPTH-1.
REQ-031 a_rd_en[r]=1 for k in r..r+DEPTH-1 (systolic stagger).
REQ-032 mac_en[r] SHALL equal a_rd_en[r] delayed one cycle (FIFO read data registered).
REQ-033 After k=DEPTH+NUM_ROWS-1 -> DONE; done=1 for exactly that one DONE cycle; then IDLE.
REQ-034 Never assert any wr_en and rd_en of the same FIFO in one cycle; never more than one a_wr_en bit.
REQ-035 Address arithmetic SHALL be ADDR_WIDTH bits; DEPTH*(NUM_ROWS+1) <= 2**ADDR_WIDTH required.

Reset
REQ-036 rst_n low SHALL immediately force IDLE, counters 0, all outputs 0 (mac_en, a_rd_en, a_wr_en all zero).
REQ-037 Reset mid-job SHALL abandon the job; outstanding response after reset release ignored per REQ-028.

Verification
REQ-038 Defaults, memory returns addr+1 with 1-cycle latency, start -> 8 b_wr_en with wr_data 1..8, then 64 a_wr_en writes (row 0 data 9..16), done 1 cycle after COMPUTE's 16 cycles.
REQ-039 Memory latency randomized 1..5 cycles -> same write sequence, never two requests outstanding.
REQ-040 COMPUTE: a_rd_en[3] high k=3..10, mac_en[3] high k=4..11, b_rd_en high k=0..7.
REQ-041 start pulsed during LOAD_A and during DONE -> no effect; exactly one done per accepted job.
REQ-042 rst_n low at k=5 of COMPUTE -> all outputs 0 same cycle, busy=0; new start runs full job correctly.
REQ-043 Spurious mem_rd_valid in IDLE and between responses -> no FIFO write, sequence unchanged.

Source files
------------

// File: rtl/matvec_seq.sv
// Sequencer for a systolic matrix-vector unit: streams vector B and matrix A from
// memory into FIFOs, then drives a staggered read/accumulate schedule over the MAC rows.
module matvec_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int NUM_ROWS   = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rd_valid,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  b_wr_en,
    output logic [NUM_ROWS-1:0]   a_wr_en,
    output logic                  b_rd_en,
    output logic [NUM_ROWS-1:0]   a_rd_en,
    output logic                  mac_clr,
    output logic [NUM_ROWS-1:0]   mac_en,
    output logic [2:0]            dbg_state
);

    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int KW = $clog2(DEPTH + NUM_ROWS);
    localparam logic [CW-1:0] C_LAST = CW'(DEPTH - 1);
    localparam logic [RW-1:0] R_LAST = RW'(NUM_ROWS - 1);
    localparam logic [KW-1:0] K_LAST = KW'(DEPTH + NUM_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_A  = 3'd2,
        S_COMPUTE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         c_q, c_d;
    logic [RW-1:0]         r_q, r_d;
    logic [KW-1:0]         k_q, k_d;
    logic                  req_q, req_d;
    logic                  fill_done_q, fill_done_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  b_wr_en_q, b_wr_en_d;
    logic [NUM_ROWS-1:0]   a_wr_en_q, a_wr_en_d;
    logic                  mac_clr_q, mac_clr_d;
    logic [NUM_ROWS-1:0]   mac_en_q, mac_en_d;
    logic [NUM_ROWS-1:0]   a_rd_en_c;
    logic                  accept;

    // A response counts only while our single request is outstanding.
    assign accept = req_q & mem_rd_valid;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            c_q         <= '0;
            r_q         <= '0;
            k_q         <= '0;
            req_q       <= 1'b0;
            fill_done_q <= 1'b0;
            wr_data_q   <= '0;
            b_wr_en_q   <= 1'b0;
            a_wr_en_q   <= '0;
            mac_clr_q   <= 1'b0;
            mac_en_q    <= '0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            r_q         <= r_d;
            k_q         <= k_d;
            req_q       <= req_d;
            fill_done_q <= fill_done_d;
            wr_data_q   <= wr_data_d;
            b_wr_en_q   <= b_wr_en_d;
            a_wr_en_q   <= a_wr_en_d;
            mac_clr_q   <= mac_clr_d;
            mac_en_q    <= mac_en_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        r_d         = r_q;
        k_d         = k_q;
        req_d       = req_q;
        fill_done_d = fill_done_q;
        wr_data_d   = wr_data_q;
        b_wr_en_d   = 1'b0;
        a_wr_en_d   = '0;
        mac_clr_d   = 1'b0;
        mac_en_d    = a_rd_en_c;
        case (state_q)
            S_IDLE: begin
                c_d         = '0;
                r_d         = '0;
                k_d         = '0;
                req_d       = 1'b0;
                fill_done_d = 1'b0;
                if (start) begin
                    state_d   = S_LOAD_B;
                    mac_clr_d = 1'b1;
                end
            end
            S_LOAD_B: begin
                if (accept) begin
                    req_d     = 1'b0;
                    wr_data_d = mem_rd_data;
                    b_wr_en_d = 1'b1;
                    if (c_q == C_LAST) begin
                        c_d     = '0;
                        state_d = S_LOAD_A;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end else if (!req_q) begin
                    req_d = 1'b1;
                end
            end
            S_LOAD_A: begin
                if (accept) begin
                    req_d     = 1'b0;
                    wr_data_d = mem_rd_data;
                    a_wr_en_d = NUM_ROWS'(1) << r_q;
                    if (c_q == C_LAST) begin
                        c_d = '0;
                        if (r_q == R_LAST) fill_done_d = 1'b1;
                        else               r_d = r_q + 1'b1;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end else if (fill_done_q) begin
                    // Last A write is on the bus this cycle; compute starts after it.
                    state_d = S_COMPUTE;
                    k_d     = '0;
                end else if (!req_q) begin
                    req_d = 1'b1;
                end
            end
            S_COMPUTE: begin
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state and counters.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        b_rd_en   = (state_q == S_COMPUTE) && (int'(k_q) < DEPTH);
        a_rd_en_c = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            a_rd_en_c[r] = (state_q == S_COMPUTE) && (int'(k_q) >= r) &&
                           (int'(k_q) < r + DEPTH);
        end
        mem_addr = '0;
        if (req_q) begin
            if (state_q == S_LOAD_A)
                mem_addr = ADDR_WIDTH'(DEPTH) * (ADDR_WIDTH'(r_q) + ADDR_WIDTH'(1)) +
                           ADDR_WIDTH'(c_q);
            else
                mem_addr = ADDR_WIDTH'(c_q);
        end
    end

    assign mem_rd_req = req_q;
    assign wr_data    = wr_data_q;
    assign b_wr_en    = b_wr_en_q;
    assign a_wr_en    = a_wr_en_q;
    assign a_rd_en    = a_rd_en_c;
    assign mac_clr    = mac_clr_q;
    assign mac_en     = mac_en_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_matvec_seq.sv
// Directed bench for matvec_seq: memory responder returning addr+1, write-order
// scoreboard, and cycle-exact checks of the compute schedule.
module tb_matvec_seq;
    localparam int DW = 8;
    localparam int D  = 8;
    localparam int NR = 8;
    localparam int AW = 8;

    logic          clk, rst_n, start;
    logic          busy, done, mem_rd_req, mem_rd_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data, wr_data;
    logic          b_wr_en, b_rd_en, mac_clr;
    logic [NR-1:0] a_wr_en, a_rd_en, mac_en;
    logic [2:0]    dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    bit lat_rand = 0;
    bit spur_pending = 0;
    bit pend = 0;
    int cnt = 0;
    logic [AW-1:0] paddr;
    logic [15:0] exp_q[$];

    matvec_seq #(.DATA_WIDTH(DW), .DEPTH(D), .NUM_ROWS(NR), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data), .wr_data(wr_data), .b_wr_en(b_wr_en),
        .a_wr_en(a_wr_en), .b_rd_en(b_rd_en), .a_rd_en(a_rd_en),
        .mac_clr(mac_clr), .mac_en(mac_en), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responder: one response per request, optional spurious strobes.
    initial begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0;
                mem_rd_valid = 1'b0;
            end else if (pend) begin
                chk("req_held", {31'd0, mem_rd_req}, 1);
                chk("addr_stable", {24'd0, mem_addr}, {24'd0, paddr});
                cnt--;
                if (cnt == 0) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = paddr + 8'd1;
                    pend = 0;
                end else begin
                    mem_rd_valid = 1'b0;
                end
            end else if (spur_pending && !mem_rd_req) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = 8'hEE;
                spur_pending = 0;
            end else begin
                mem_rd_valid = 1'b0;
                if (mem_rd_req) begin
                    pend  = 1;
                    paddr = mem_addr;
                    cnt   = lat_rand ? int'($urandom_range(1, 5)) : 1;
                end
            end
        end
    end

    // Write monitor / scoreboard against exp_q.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (b_wr_en || a_wr_en != '0) begin
                    logic [15:0] got;
                    logic [7:0] row;
                    row = 8'hB0;
                    if (a_wr_en != '0) begin
                        chk("a_wr_onehot", $countones(a_wr_en), 1);
                        chk("a_wr_rd_excl", {24'd0, a_wr_en & a_rd_en}, 0);
                        for (int r = 0; r < NR; r++) if (a_wr_en[r]) row = 8'(r);
                    end
                    if (b_wr_en) chk("b_wr_rd_excl", {31'd0, b_rd_en}, 0);
                    got = {row, wr_data};
                    if (exp_q.size() == 0) chk("unexpected_write", {16'd0, got}, 32'hFFFF_FFFF);
                    else chk("wr_seq", {16'd0, got}, {16'd0, exp_q.pop_front()});
                end
                if (done) done_cnt++;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_req"}, {31'd0, mem_rd_req}, 0);
        chk({tag, "_addr"}, {24'd0, mem_addr}, 0);
        chk({tag, "_wdata"}, {24'd0, wr_data}, 0);
        chk({tag, "_bwr"}, {31'd0, b_wr_en}, 0);
        chk({tag, "_awr"}, {24'd0, a_wr_en}, 0);
        chk({tag, "_brd"}, {31'd0, b_rd_en}, 0);
        chk({tag, "_ard"}, {24'd0, a_rd_en}, 0);
        chk({tag, "_clr"}, {31'd0, mac_clr}, 0);
        chk({tag, "_mac"}, {24'd0, mac_en}, 0);
        chk({tag, "_state"}, {29'd0, dbg_state}, 0);
    endtask

    // Walks the compute window from k=0; rst_at>=0 aborts there with reset.
    task automatic check_compute(input int rst_at, input bit poke_done);
        int t;
        logic [NR-1:0] ea, em;
        t = 0;
        while (!b_rd_en && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            chk("compute_entry_timeout", 0, 1);
            return;
        end
        chk("done_cnt_pre_compute", done_cnt, 0);
        for (int k = 0; k < D + NR; k++) begin
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_outputs_zero("rst_mid");
                exp_q.delete();
                return;
            end
            ea = '0;
            em = '0;
            for (int r = 0; r < NR; r++) begin
                ea[r] = (k >= r) && (k <= r + D - 1);
                em[r] = (k >= r + 1) && (k <= r + D);
            end
            chk("b_rd_en", {31'd0, b_rd_en}, (k < D) ? 1 : 0);
            chk("a_rd_en", {24'd0, a_rd_en}, {24'd0, ea});
            chk("mac_en", {24'd0, mac_en}, {24'd0, em});
            chk("a_rd_en3", {31'd0, a_rd_en[3]}, (k >= 3 && k <= 10) ? 1 : 0);
            chk("mac_en3", {31'd0, mac_en[3]}, (k >= 4 && k <= 11) ? 1 : 0);
            chk("busy_compute", {31'd0, busy}, 1);
            chk("done_compute", {31'd0, done}, 0);
            @(negedge clk);
        end
        chk("done_pulse", {31'd0, done}, 1);
        chk("busy_done", {31'd0, busy}, 1);
        chk("mac_en_done", {24'd0, mac_en}, 0);
        if (poke_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_low_after", {31'd0, done}, 0);
        chk("busy_low_after", {31'd0, busy}, 0);
    endtask

    task automatic run_job(input bit rnd, input bit poke_a, input bit poke_done,
                           input int rst_at, input bit spur);
        int t;
        lat_rand = rnd;
        done_cnt = 0;
        exp_q.delete();
        for (int i = 0; i < D; i++) exp_q.push_back({8'hB0, 8'(i + 1)});
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < D; c++) exp_q.push_back({8'(r), 8'(D * (r + 1) + c + 1)});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mac_clr_pulse", {31'd0, mac_clr}, 1);
        chk("busy_start", {31'd0, busy}, 1);
        if (spur) spur_pending = 1;
        @(negedge clk);
        chk("mac_clr_once", {31'd0, mac_clr}, 0);
        if (spur) begin
            t = 0;
            while (exp_q.size() > 8 + NR * D - 3 && t < 500) begin
                @(negedge clk);
                t++;
            end
            spur_pending = 1;
        end
        if (poke_a) begin
            t = 0;
            while (exp_q.size() > NR * D - 5 && t < 2000) begin
                @(negedge clk);
                t++;
            end
            chk("reach_load_a", {29'd0, dbg_state}, 2);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("mac_clr_ignored", {31'd0, mac_clr}, 0);
        end
        check_compute(rst_at, poke_done);
        if (rst_at < 0) begin
            chk("writes_left", exp_q.size(), 0);
            repeat (4) @(negedge clk);
            chk("idle_busy", {31'd0, busy}, 0);
            chk("done_count", done_cnt, 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        spur_pending = 1;
        repeat (3) @(negedge clk);
        chk("idle_spur_state", {29'd0, dbg_state}, 0);
        chk("idle_spur_nowrite", {31'd0, b_wr_en}, 0);
        run_job(1'b0, 1'b0, 1'b0, -1, 1'b1);
        run_job(1'b1, 1'b1, 1'b1, -1, 1'b0);
        run_job(1'b0, 1'b0, 1'b0, 5, 1'b0);
        @(negedge clk);
        check_outputs_zero("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        run_job(1'b0, 1'b0, 1'b0, -1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
